// File: rtl/rv64_mem_pkg.sv
// rv64_mem_pkg: shared state type, NOP constant and address checks
// for the rv64_mem_responder memory slice.
package rv64_mem_pkg;

   typedef enum logic {
      LOAD = 1'b0,
      RUN  = 1'b1
   } mem_state_e;

   localparam logic [31:0] NOP_INST = 32'h00000013;

   // off is relative to BASE_ADDR; window is 8 bytes per word
   function automatic logic off_in_range(
      input logic [63:0] off,
      input int unsigned aw
   );
      return (off >> (aw + 3)) == 64'd0;
   endfunction

   function automatic logic off_aligned(
      input logic [2:0] lo,
      input logic [2:0] mask
   );
      return (lo & mask) == 3'b000;
   endfunction

endpackage

// File: rtl/rv64_mem_array.sv
// rv64_mem_array: DEPTH x 64 storage, one half-enabled write port
// and two registered read ports (read-before-write).
module rv64_mem_array #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [1:0]        whe,
   input  logic [63:0]       wdata,
   input  logic              a_en,
   input  logic [ADDR_W-1:0] a_addr,
   output logic [63:0]       a_data,
   input  logic              b_en,
   input  logic [ADDR_W-1:0] b_addr,
   output logic [63:0]       b_data
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [63:0] mem [DEPTH];
   logic [63:0] a_data_q, a_data_d;
   logic [63:0] b_data_q, b_data_d;

   always_ff @(posedge clk) begin
      if (we && whe[0]) mem[waddr][31:0]  <= wdata[31:0];
      if (we && whe[1]) mem[waddr][63:32] <= wdata[63:32];
   end

   always_comb begin
      a_data_d = a_data_q;
      b_data_d = b_data_q;
      if (a_en) a_data_d = mem[a_addr];
      if (b_en) b_data_d = mem[b_addr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_data_q <= '0;
         b_data_q <= '0;
      end else begin
         a_data_q <= a_data_d;
         b_data_q <= b_data_d;
      end
   end

   assign a_data = a_data_q;
   assign b_data = b_data_q;

endmodule

// File: rtl/rv64_mem_responder.sv
// rv64_mem_responder: loader-then-run memory for the RV64IF core buses.
// Define MEM_MISALIGN_TRAP_EN to fault misaligned fetch/data accesses.
module rv64_mem_responder #(
   parameter int          ADDR_W    = 10,
   parameter logic [63:0] BASE_ADDR = 64'h0
) (
   input  logic        in_Clk,
   input  logic        Rst_N,
   input  logic        in_load_valid,
   input  logic [31:0] in_load_data,
   input  logic        in_load_last,
   output logic        out_load_ready,
   output logic        out_boot_done,
   output logic [63:0] out_init_addr,
   input  logic [63:0] in_inst_addr,
   output logic [31:0] out_inst,
   output logic        out_inst_valid,
   input  logic [63:0] in_addr,
   input  logic        in_rd_en,
   input  logic        in_wr_en,
   input  logic [63:0] in_wr_data,
   output logic [63:0] out_rd_data,
   output logic        out_rd_valid,
   output logic        out_fault
);

   import rv64_mem_pkg::*;

   localparam logic [ADDR_W:0] LAST_SLOT = '1;

   mem_state_e      state_q, state_d;
   logic [ADDR_W:0] load_ptr_q, load_ptr_d;
   logic            boot_done_q, boot_done_d;
   logic            inst_valid_q, inst_valid_d;
   logic            inst_bad_q, inst_bad_d;
   logic            inst_hi_q, inst_hi_d;
   logic            rd_valid_q, rd_valid_d;
   logic            rd_bad_q, rd_bad_d;
   logic            fault_q, fault_d;

   logic [63:0] i_off, d_off;
   logic        i_ok, d_ok, run, load_acc;
   logic        we;
   logic [ADDR_W-1:0] waddr;
   logic [1:0]  whe;
   logic [63:0] wdata, a_data, b_data;

   assign i_off = in_inst_addr - BASE_ADDR;
   assign d_off = in_addr - BASE_ADDR;

`ifdef MEM_MISALIGN_TRAP_EN
   assign i_ok = off_in_range(i_off, ADDR_W) &&
                 off_aligned(i_off[2:0], 3'b011);
   assign d_ok = off_in_range(d_off, ADDR_W) &&
                 off_aligned(d_off[2:0], 3'b111);
`else
   assign i_ok = off_in_range(i_off, ADDR_W);
   assign d_ok = off_in_range(d_off, ADDR_W);
`endif

   assign run      = (state_q == RUN);
   assign load_acc = !run && in_load_valid;

   always_comb begin
      state_d    = state_q;
      load_ptr_d = load_ptr_q;
      if (load_acc) begin
         load_ptr_d = load_ptr_q + 1'b1;
         if (in_load_last || load_ptr_q == LAST_SLOT) state_d = RUN;
      end
      boot_done_d  = (state_d == RUN);
      inst_valid_d = run;
      inst_bad_d   = inst_bad_q;
      inst_hi_d    = inst_hi_q;
      if (run) begin
         inst_bad_d = !i_ok;
         inst_hi_d  = i_off[2];
      end
      rd_valid_d = run && in_rd_en;
      rd_bad_d   = rd_bad_q;
      if (rd_valid_d) rd_bad_d = !d_ok;
      fault_d = run && (!i_ok || ((in_rd_en || in_wr_en) && !d_ok));
   end

   // loader owns the write port in LOAD, core stores in RUN
   always_comb begin
      we    = 1'b0;
      waddr = d_off[ADDR_W+2:3];
      whe   = 2'b11;
      wdata = in_wr_data;
      if (load_acc) begin
         we    = 1'b1;
         waddr = load_ptr_q[ADDR_W:1];
         whe   = load_ptr_q[0] ? 2'b10 : 2'b01;
         wdata = {in_load_data, in_load_data};
      end else if (run && in_wr_en && d_ok) begin
         we = 1'b1;
      end
   end

   always_ff @(posedge in_Clk or negedge Rst_N) begin
      if (!Rst_N) begin
         state_q      <= LOAD;
         load_ptr_q   <= '0;
         boot_done_q  <= 1'b0;
         inst_valid_q <= 1'b0;
         inst_bad_q   <= 1'b0;
         inst_hi_q    <= 1'b0;
         rd_valid_q   <= 1'b0;
         rd_bad_q     <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         load_ptr_q   <= load_ptr_d;
         boot_done_q  <= boot_done_d;
         inst_valid_q <= inst_valid_d;
         inst_bad_q   <= inst_bad_d;
         inst_hi_q    <= inst_hi_d;
         rd_valid_q   <= rd_valid_d;
         rd_bad_q     <= rd_bad_d;
         fault_q      <= fault_d;
      end
   end

   rv64_mem_array #(.ADDR_W(ADDR_W)) u_array (
      .clk    (in_Clk),
      .rst_n  (Rst_N),
      .we     (we),
      .waddr  (waddr),
      .whe    (whe),
      .wdata  (wdata),
      .a_en   (run && i_ok),
      .a_addr (i_off[ADDR_W+2:3]),
      .a_data (a_data),
      .b_en   (run && in_rd_en && d_ok),
      .b_addr (d_off[ADDR_W+2:3]),
      .b_data (b_data)
   );

   assign out_load_ready = !run;
   assign out_boot_done  = boot_done_q;
   assign out_init_addr  = BASE_ADDR;
   assign out_inst_valid = inst_valid_q;
   assign out_inst       = inst_bad_q ? NOP_INST :
                           (inst_hi_q ? a_data[63:32] : a_data[31:0]);
   assign out_rd_valid   = rd_valid_q;
   assign out_rd_data    = rd_bad_q ? 64'd0 : b_data;
   assign out_fault      = fault_q;

endmodule

// File: tb/tb_rv64_mem_responder.sv
// tb_rv64_mem_responder: directed scenarios plus randomized traffic
// checked against a word-array reference model.
module tb_rv64_mem_responder;

   localparam int          AW    = 6;
   localparam int          DEPTH = 1 << AW;
   localparam logic [63:0] BASE  = 64'h1000;
   localparam logic [31:0] NOP   = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_load_valid = 1'b0;
   logic [31:0] in_load_data = '0;
   logic        in_load_last = 1'b0;
   logic        out_load_ready, out_boot_done;
   logic [63:0] out_init_addr;
   logic [63:0] in_inst_addr = BASE;
   logic [31:0] out_inst;
   logic        out_inst_valid;
   logic [63:0] in_addr = BASE;
   logic        in_rd_en = 1'b0;
   logic        in_wr_en = 1'b0;
   logic [63:0] in_wr_data = '0;
   logic [63:0] out_rd_data;
   logic        out_rd_valid, out_fault;

   always #5 clk = ~clk;

   rv64_mem_responder #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
      .in_Clk(clk), .Rst_N(rst_n),
      .in_load_valid(in_load_valid), .in_load_data(in_load_data),
      .in_load_last(in_load_last), .out_load_ready(out_load_ready),
      .out_boot_done(out_boot_done), .out_init_addr(out_init_addr),
      .in_inst_addr(in_inst_addr), .out_inst(out_inst),
      .out_inst_valid(out_inst_valid), .in_addr(in_addr),
      .in_rd_en(in_rd_en), .in_wr_en(in_wr_en), .in_wr_data(in_wr_data),
      .out_rd_data(out_rd_data), .out_rd_valid(out_rd_valid),
      .out_fault(out_fault)
   );

   int checks = 0;
   int failures = 0;

   logic [63:0] mm [DEPTH];
   bit          m_run;
   int          m_ptr;
   logic [31:0] e_inst;
   bit          e_iv, e_rv, e_fault;
   logic [63:0] e_rd;

   function automatic bit fetch_ok(input logic [63:0] a);
      logic [63:0] off;
      bit ok;
      off = a - BASE;
      ok = off < 64'(8 * DEPTH);
`ifdef MEM_MISALIGN_TRAP_EN
      if (off[1:0] != 2'b00) ok = 1'b0;
`endif
      return ok;
   endfunction

   function automatic bit data_ok(input logic [63:0] a);
      logic [63:0] off;
      bit ok;
      off = a - BASE;
      ok = off < 64'(8 * DEPTH);
`ifdef MEM_MISALIGN_TRAP_EN
      if (off[2:0] != 3'b000) ok = 1'b0;
`endif
      return ok;
   endfunction

   task automatic idle();
      in_load_valid = 1'b0;
      in_load_last  = 1'b0;
      in_inst_addr  = BASE;
      in_addr       = BASE;
      in_rd_en      = 1'b0;
      in_wr_en      = 1'b0;
   endtask

   // reference model: predicts responses for the inputs currently driven
   task automatic tick();
      logic [63:0] io, dof;
      int wi, wd;
      io = in_inst_addr - BASE;
      dof = in_addr - BASE;
      wi = int'(io >> 3);
      wd = int'(dof >> 3);
      if (!m_run) begin
         e_iv = 0; e_rv = 0; e_fault = 0;
         if (in_load_valid) begin
            if (m_ptr % 2 == 0) mm[m_ptr / 2][31:0] = in_load_data;
            else                mm[m_ptr / 2][63:32] = in_load_data;
            m_ptr++;
            if (in_load_last || m_ptr == 2 * DEPTH) m_run = 1;
         end
      end else begin
         e_iv = 1;
         if (fetch_ok(in_inst_addr))
            e_inst = io[2] ? mm[wi][63:32] : mm[wi][31:0];
         else
            e_inst = NOP;
         e_fault = !fetch_ok(in_inst_addr) ||
                   ((in_rd_en || in_wr_en) && !data_ok(in_addr));
         e_rv = in_rd_en;
         if (in_rd_en) e_rd = data_ok(in_addr) ? mm[wd] : 64'd0;
         if (in_wr_en && data_ok(in_addr)) mm[wd] = in_wr_data;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_run = 0; m_ptr = 0;
      e_iv = 0; e_rv = 0; e_fault = 0; e_inst = '0; e_rd = '0;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      #2;
      checks++;
      if (out_load_ready !== 1'b1 || out_boot_done !== 1'b0 ||
          out_inst_valid !== 1'b0 || out_rd_valid !== 1'b0 ||
          out_fault !== 1'b0) begin
         failures++;
         $display("FAIL reset_flags got rdy=%b boot=%b iv=%b rv=%b flt=%b",
                  out_load_ready, out_boot_done, out_inst_valid,
                  out_rd_valid, out_fault);
      end
      checks++;
      if (out_inst !== 32'd0 || out_rd_data !== 64'd0) begin
         failures++;
         $display("FAIL reset_data got inst=%h rd=%h want 0",
                  out_inst, out_rd_data);
      end
      checks++;
      if (out_init_addr !== BASE) begin
         failures++;
         $display("FAIL init_addr got %h want %h", out_init_addr, BASE);
      end
      do_reset();
   endtask

   task automatic test_load_boot();
      for (int i = 0; i < 4; i++) begin
         in_load_valid = 1'b1;
         in_load_data  = 32'(17 * (i + 1));
         in_load_last  = (i == 3);
         tick();
         checks++;
         if (out_boot_done !== (i == 3) || out_load_ready !== (i != 3)) begin
            failures++;
            $display("FAIL boot_edge word%0d got boot=%b rdy=%b",
                     i, out_boot_done, out_load_ready);
         end
      end
      idle();
      in_inst_addr = BASE;
      tick();
      in_inst_addr = BASE + 4;
      checks++;
      if (out_inst_valid !== 1'b1 || out_inst !== 32'h11 || out_fault !== 1'b0) begin
         failures++;
         $display("FAIL fetch0 got v=%b inst=%h want 1/00000011",
                  out_inst_valid, out_inst);
      end
      tick();
      checks++;
      if (out_inst !== 32'h22) begin
         failures++;
         $display("FAIL fetch4 got %h want 00000022", out_inst);
      end
      idle();
   endtask

   task automatic test_store_load();
      in_addr = BASE + 64'h100;
      in_wr_en = 1'b1;
      in_wr_data = 64'hDEADBEEF_CAFEF00D;
      tick();
      in_wr_en = 1'b0;
      in_rd_en = 1'b1;
      tick();
      in_rd_en = 1'b0;
      checks++;
      if (out_rd_valid !== 1'b1 || out_rd_data !== 64'hDEADBEEF_CAFEF00D) begin
         failures++;
         $display("FAIL store_load got v=%b d=%h want 1/deadbeefcafef00d",
                  out_rd_valid, out_rd_data);
      end
      tick();
      checks++;
      if (out_rd_valid !== 1'b0) begin
         failures++;
         $display("FAIL rd_pulse got %b want 0", out_rd_valid);
      end
   endtask

   task automatic test_rw_same();
      in_addr = BASE + 64'h108;
      in_wr_en = 1'b1;
      in_wr_data = 64'h5;
      tick();
      in_rd_en = 1'b1;
      in_wr_data = 64'h9;
      tick();
      checks++;
      if (out_rd_data !== 64'h5) begin
         failures++;
         $display("FAIL rw_old got %h want 5", out_rd_data);
      end
      in_wr_en = 1'b0;
      tick();
      in_rd_en = 1'b0;
      checks++;
      if (out_rd_data !== 64'h9) begin
         failures++;
         $display("FAIL rw_new got %h want 9", out_rd_data);
      end
   endtask

   task automatic test_oor();
      in_addr = BASE + 64'(8 * DEPTH);
      in_inst_addr = BASE + 64'(8 * DEPTH);
      in_rd_en = 1'b1;
      tick();
      checks++;
      if (out_rd_data !== 64'd0 || out_inst !== NOP || out_fault !== 1'b1) begin
         failures++;
         $display("FAIL oor_access got d=%h inst=%h flt=%b",
                  out_rd_data, out_inst, out_fault);
      end
      idle();
      tick();
      checks++;
      if (out_fault !== 1'b0) begin
         failures++;
         $display("FAIL oor_fault_pulse got %b want 0", out_fault);
      end
      in_addr = BASE + 64'(8 * DEPTH);
      in_wr_en = 1'b1;
      in_wr_data = 64'h1234_5678_9ABC_DEF0;
      tick();
      checks++;
      if (out_fault !== 1'b1) begin
         failures++;
         $display("FAIL oor_store_fault got %b want 1", out_fault);
      end
      in_wr_en = 1'b0;
      in_addr = BASE - 64'd8;
      in_rd_en = 1'b1;
      tick();
      checks++;
      if (out_fault !== 1'b1 || out_rd_data !== 64'd0) begin
         failures++;
         $display("FAIL below_base got flt=%b d=%h", out_fault, out_rd_data);
      end
      in_addr = BASE;
      tick();
      in_rd_en = 1'b0;
      checks++;
      if (out_rd_data !== 64'h00000022_00000011) begin
         failures++;
         $display("FAIL oor_no_alias got %h want 0000002200000011", out_rd_data);
      end
   endtask

   task automatic test_reset_midload();
      do_reset();
      for (int i = 0; i < 2; i++) begin
         in_load_valid = 1'b1;
         in_load_data  = 32'hA1 + 32'(i);
         tick();
      end
      in_load_data = 32'hA3;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_load_ready !== 1'b1 || out_boot_done !== 1'b0) begin
         failures++;
         $display("FAIL midload_reset got rdy=%b boot=%b want 1/0",
                  out_load_ready, out_boot_done);
      end
      do_reset();
      for (int i = 0; i < 2; i++) begin
         in_load_valid = 1'b1;
         in_load_data  = 32'hB1 + 32'(i);
         in_load_last  = (i == 1);
         tick();
      end
      idle();
      in_addr = BASE + 64'h8;
      in_rd_en = 1'b1;
      tick();
      checks++;
      if (out_rd_data !== 64'h00000044_00000033) begin
         failures++;
         $display("FAIL persist_w1 got %h want 0000004400000033", out_rd_data);
      end
      in_addr = BASE + 64'h100;
      tick();
      in_rd_en = 1'b0;
      checks++;
      if (out_rd_data !== 64'hDEADBEEF_CAFEF00D) begin
         failures++;
         $display("FAIL persist_100 got %h", out_rd_data);
      end
      in_inst_addr = BASE + 64'h4;
      tick();
      checks++;
      if (out_inst !== 32'hB2) begin
         failures++;
         $display("FAIL reload_fetch got %h want 000000b2", out_inst);
      end
   endtask

   task automatic test_image_full();
      do_reset();
      for (int i = 0; i < 2 * DEPTH; i++) begin
         in_load_valid = 1'b1;
         in_load_data  = $urandom;
         in_rd_en      = 1'b1;
         in_wr_en      = 1'b1;
         in_addr       = BASE + 64'($urandom_range(0, DEPTH - 1) * 8);
         in_wr_data    = {$urandom, $urandom};
         tick();
         checks++;
         if (out_boot_done !== (i == 2 * DEPTH - 1) ||
             out_rd_valid !== 1'b0 || out_fault !== 1'b0) begin
            failures++;
            $display("FAIL image_full slot%0d got boot=%b rv=%b flt=%b",
                     i, out_boot_done, out_rd_valid, out_fault);
         end
      end
      idle();
      in_load_valid = 1'b1;
      in_load_data = 32'hFFFF_FFFF;
      tick();
      idle();
   endtask

   task automatic test_misalign();
      in_addr = BASE + 64'h103;
      in_inst_addr = BASE + 64'h102;
      in_rd_en = 1'b1;
      tick();
      in_rd_en = 1'b0;
      checks++;
      if (out_rd_data !== e_rd || out_inst !== e_inst || out_fault !== e_fault) begin
         failures++;
         $display("FAIL misalign_ld got d=%h i=%h f=%b want %h %h %b",
                  out_rd_data, out_inst, out_fault, e_rd, e_inst, e_fault);
      end
      in_addr = BASE + 64'h105;
      in_inst_addr = BASE;
      in_wr_en = 1'b1;
      in_wr_data = 64'h0123_4567_89AB_CDEF;
      tick();
      in_wr_en = 1'b0;
      in_addr = BASE + 64'h100;
      in_rd_en = 1'b1;
      tick();
      in_rd_en = 1'b0;
      checks++;
      if (out_rd_data !== e_rd) begin
         failures++;
         $display("FAIL misalign_st got %h want %h", out_rd_data, e_rd);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         int k;
         k = $urandom_range(0, 9);
         in_inst_addr = BASE + 64'($urandom_range(0, 8 * DEPTH - 1));
         if (k == 0) in_inst_addr = BASE + 64'(8 * DEPTH) + 64'($urandom_range(0, 64));
         if ($urandom_range(0, 3) != 0) in_inst_addr[1:0] = 2'b00;
         in_addr = BASE + 64'($urandom_range(0, 8 * DEPTH - 1));
         if (k == 1) in_addr = {$urandom, $urandom};
         if ($urandom_range(0, 3) != 0) in_addr[2:0] = 3'b000;
         in_rd_en = $urandom_range(0, 1) == 1;
         in_wr_en = $urandom_range(0, 2) == 0;
         in_wr_data = {$urandom, $urandom};
         tick();
         checks++;
         if (out_inst_valid !== e_iv || (e_iv && out_inst !== e_inst) ||
             out_rd_valid !== e_rv || (e_rv && out_rd_data !== e_rd) ||
             out_fault !== e_fault || out_boot_done !== 1'b1) begin
            failures++;
            $display("FAIL random%0d got iv=%b i=%h rv=%b d=%h f=%b want %b %h %b %h %b",
                     n, out_inst_valid, out_inst, out_rd_valid, out_rd_data,
                     out_fault, e_iv, e_inst, e_rv, e_rd, e_fault);
         end
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_load_boot();
      test_store_load();
      test_rw_same();
      test_oor();
      test_reset_midload();
      test_image_full();
      test_misalign();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
